// File: rtl/pixel_streamer_if.sv
// pixel_streamer_if: byte-stream handshake in, converted pixel bus out
// master: byte source / pixel consumer side; slave: the streamer
// Signals: in_valid/in_data/in_ready byte handshake;
//          input_pixel/pixel_counter/pixel_valid/frame_done toward the network
interface pixel_streamer_if #(
    parameter int BITS = 24
);
    logic            in_valid;
    logic [7:0]      in_data;
    logic            in_ready;
    logic [BITS-1:0] input_pixel;
    logic [9:0]      pixel_counter;
    logic            pixel_valid;
    logic            frame_done;
    modport master (
        output in_valid, in_data,
        input  in_ready, input_pixel, pixel_counter, pixel_valid, frame_done
    );
    modport slave (
        input  in_valid, in_data,
        output in_ready, input_pixel, pixel_counter, pixel_valid, frame_done
    );
endinterface

// File: rtl/pixel_streamer.sv
// pixel_streamer: converts a 28x28 byte frame to fixed-point pixels for the fully connected layer
// Ports: clk; reset (async, active-low); start (begin frame); abort (drop frame);
//        layer_done (network finished); busy (RECV or WAIT_NN);
//        bus (slave): byte handshake in, input_pixel/pixel_counter/pixel_valid/frame_done out
module pixel_streamer #(
    parameter int BITS  = 24,
    parameter int WIDTH = 784,
    parameter int FRAC  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic            layer_done,
    output logic            busy,
    pixel_streamer_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, RECV = 2'd1, WAIT_NN = 2'd2;
    if (FRAC < 8 || FRAC > BITS - 1) begin : g_frac_check
        $error("pixel_streamer: FRAC must satisfy 8 <= FRAC <= BITS-1");
    end
    logic [1:0] state, state_nxt;
    logic [9:0] idx, idx_nxt;
    logic       accept, last, emit;
    assign bus.in_ready = state == RECV;
    assign busy         = state == RECV || state == WAIT_NN;
    assign accept       = bus.in_ready && bus.in_valid;
    assign last         = idx == 10'(WIDTH - 1);
    // an accept in the abort cycle is swallowed so no partial frame leaks out
    assign emit         = accept && !abort;
    always_comb begin
        state_nxt = abort                         ? IDLE
                  : (state == IDLE && start)      ? RECV
                  : (accept && last)              ? WAIT_NN
                  : (state == WAIT_NN && layer_done) ? IDLE
                  : state;
        idx_nxt   = (abort || (state == IDLE && start)) ? '0
                  : accept                               ? idx + 10'd1
                  : idx;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            idx               <= '0;
            bus.pixel_valid   <= 1'b0;
            bus.frame_done    <= 1'b0;
            bus.input_pixel   <= '0;
            bus.pixel_counter <= '0;
        end else begin
            state           <= state_nxt;
            idx             <= idx_nxt;
            bus.pixel_valid <= emit;
            bus.frame_done  <= emit && last;
            if (emit) begin
                // byte/256 in unsigned fixed point with FRAC fractional bits
                bus.input_pixel   <= BITS'(bus.in_data) << (FRAC - 8);
                bus.pixel_counter <= idx;
            end
        end
    end
endmodule

// File: tb/tb_pixel_streamer.sv
// tb_pixel_streamer: scoreboard bench for pixel_streamer
module tb_pixel_streamer;
    localparam int BITS = 24, WIDTH = 784, FRAC = 16;
    localparam logic [1:0] IDLE = 2'd0, RECV = 2'd1, WAIT_NN = 2'd2;
    typedef struct {
        logic [7:0]  din;
        logic [23:0] pix;
    } vec_t;
    typedef struct {
        logic [23:0] pix;
        logic [9:0]  cnt;
        logic        fd;
    } exp_t;
    logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, layer_done = 1'b0, busy;
    pixel_streamer_if #(.BITS(BITS)) intf ();
    pixel_streamer #(.BITS(BITS), .WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .layer_done(layer_done), .busy(busy), .bus(intf.slave)
    );
    always #5 clk = ~clk;
    int total = 0, bad = 0;
    vec_t tbl[6];
    logic use_tbl = 1'b0;
    logic [23:0] tbl_exp = '0;
    exp_t q[$];
    exp_t e;
    logic [1:0] m_state = IDLE;
    logic [9:0] m_idx = '0;
    logic [23:0] last_pix = '0;
    logic [9:0] last_cnt = '0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask
    // checks outputs produced by the last edge, then predicts the coming edge
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            #1;
            chk("rst_in_ready", intf.in_ready, 0);
            chk("rst_pixel_valid", intf.pixel_valid, 0);
            chk("rst_frame_done", intf.frame_done, 0);
            chk("rst_busy", busy, 0);
            chk("rst_input_pixel", intf.input_pixel, 0);
            chk("rst_pixel_counter", intf.pixel_counter, 0);
            m_state = IDLE;
            m_idx = '0;
            last_pix = '0;
            last_cnt = '0;
            q.delete();
        end else begin
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("pixel_valid", intf.pixel_valid, 1);
                chk("input_pixel", intf.input_pixel, e.pix);
                chk("pixel_counter", intf.pixel_counter, e.cnt);
                chk("frame_done", intf.frame_done, e.fd);
                last_pix = e.pix;
                last_cnt = e.cnt;
            end else begin
                chk("no_pixel_valid", intf.pixel_valid, 0);
                chk("no_frame_done", intf.frame_done, 0);
                chk("hold_input_pixel", intf.input_pixel, last_pix);
                chk("hold_pixel_counter", intf.pixel_counter, last_cnt);
            end
            chk("in_ready", intf.in_ready, m_state == RECV);
            chk("busy", busy, m_state != IDLE);
            if (abort) begin
                m_state = IDLE;
                m_idx = '0;
            end else if (m_state == IDLE) begin
                if (start) begin
                    m_state = RECV;
                    m_idx = '0;
                end
            end else if (m_state == RECV) begin
                if (intf.in_valid) begin
                    e.pix = use_tbl ? tbl_exp : 24'(intf.in_data) * 24'd256;
                    e.cnt = m_idx;
                    e.fd = m_idx == 10'(WIDTH - 1);
                    q.push_back(e);
                    if (e.fd) m_state = WAIT_NN;
                    else m_idx = m_idx + 10'd1;
                end
            end else if (layer_done) begin
                m_state = IDLE;
            end
        end
    end
    task automatic cyc(input logic s, input logic a, input logic v, input logic ld, input logic [7:0] d);
        start = s;
        abort = a;
        intf.in_valid = v;
        intf.in_data = d;
        layer_done = ld;
        @(posedge clk);
        #1;
    endtask
    function automatic logic [7:0] rb();
        return 8'($urandom_range(0, 255));
    endfunction
    initial begin
        tbl[0] = '{8'h00, 24'h000000};
        tbl[1] = '{8'h80, 24'h008000};
        tbl[2] = '{8'hFF, 24'h00FF00};
        tbl[3] = '{8'h01, 24'h000100};
        tbl[4] = '{8'h7F, 24'h007F00};
        tbl[5] = '{8'h55, 24'h005500};
        intf.in_valid = 1'b0;
        intf.in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        use_tbl = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tbl_exp = tbl[i].pix;
            cyc(0, 0, 1, 0, tbl[i].din);
        end
        use_tbl = 1'b0;
        for (int i = 6; i < WIDTH; i++) cyc(0, 0, 1, 0, rb());
        cyc(1, 0, 1, 0, rb());
        cyc(1, 0, 1, 0, rb());
        cyc(1, 0, 1, 1, rb());
        repeat (3) cyc(0, 0, 1, 0, rb());
        cyc(1, 0, 0, 0, 0);
        for (int n = 0; n < WIDTH; ) begin
            logic v;
            v = $urandom_range(0, 2) != 0;
            cyc(n == 100, 0, v, 0, rb());
            if (v) n++;
        end
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) cyc(0, 0, 1, 0, rb());
        cyc(0, 1, 1, 0, rb());
        repeat (2) cyc(0, 0, 1, 0, rb());
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < WIDTH; i++) cyc(0, 0, 1, 0, rb());
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) cyc(0, 0, 1, 0, rb());
        intf.in_valid = 1'b0;
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        cyc(0, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (3) cyc(0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pixel_streamer.md
Name: pixel_streamer

Overview:
- Upstream stage of the digit-recognition network. Accepts a 28x28 grayscale frame as a byte stream over a valid/ready handshake.
- Converts each byte to the network's unsigned fixed-point format and presents it, with its index, to the fully connected layer.
- Blocks the next frame until the network reports completion, so one frame is in flight at a time.

Parameters:
- BITS, 24: width of the fixed-point pixel word driven to the network.
- WIDTH, 784: pixels per frame.
- FRAC, 16: fractional bits of the pixel word. Legal range 8 <= FRAC <= BITS-1, enforced by an elaboration-time check.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin receiving a frame.
- abort  input  1  synchronous abort of the current frame.
- in_valid  input  1  byte source has data.
- in_data  input  8  grayscale byte, 0 = black, 255 = white.
- in_ready  output  1  streamer accepts a byte this cycle.
- input_pixel  output  BITS  converted pixel value.
- pixel_counter  output  10  index 0..WIDTH-1 of input_pixel.
- pixel_valid  output  1  input_pixel/pixel_counter valid this cycle.
- frame_done  output  1  one-cycle pulse with the last pixel of a frame.
- layer_done  input  1  network finished current frame.
- busy  output  1  high in RECV and WAIT_NN.

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE. in_ready, pixel_valid, frame_done, busy all 0. input_pixel = 0, pixel_counter = 0, internal index = 0.
- FSM states:
  - IDLE: in_ready = 0. start = 1 moves to RECV and clears the index to 0.
  - RECV: in_ready = 1 combinationally from state. A byte is accepted on any cycle with in_valid & in_ready.
  - WAIT_NN: in_ready = 0. layer_done = 1 returns to IDLE. layer_done in any other state is ignored.
- Acceptance, one-cycle latency: the cycle after an accept, pixel_valid = 1, input_pixel = zero-extended in_data shifted left by FRAC-8 (value = byte/256), pixel_counter = index of that byte. The index then increments.
- Examples: byte 0x80 with FRAC = 16 gives input_pixel = 0x008000. Byte 0xFF gives 0x00FF00.
- Cycles without an accept: pixel_valid = 0. input_pixel and pixel_counter hold their last values.
- Last byte (index WIDTH-1): on its accept the FSM moves to WAIT_NN. The following cycle has pixel_valid = 1, frame_done = 1, pixel_counter = WIDTH-1. in_ready is 0 from the cycle after that accept, so the source cannot overrun into the next frame.
- Source stalls (in_valid = 0) of any length are legal. Index and outputs hold.
- start in RECV or WAIT_NN is ignored.
- abort = 1 in any state: next state IDLE, index = 0, in_ready = 0. The pixel_valid/frame_done of an accept made in that same cycle are suppressed, so nothing partial is emitted. abort has priority over start, accept and layer_done.
- start and layer_done in the same cycle in WAIT_NN: go to IDLE only; start must be re-issued.
- busy = 1 exactly in RECV and WAIT_NN.
- Reset asserted mid-frame: immediate return to reset values. No frame_done is generated.

Test Plan:
- Reset, start, stream 784 bytes with in_valid held high -> 784 pixel_valid pulses with counter 0..783 on consecutive cycles; frame_done only with counter 783; in_ready low from the cycle after the 784th accept; busy high until layer_done.
- Bytes 0x00, 0x80, 0xFF at FRAC = 16 -> input_pixel 0x000000, 0x008000, 0x00FF00.
- Random in_valid gaps during a frame -> pixel_valid only after accepted cycles; counter strictly increments by 1; outputs hold during gaps.
- After frame_done, drive in_valid high and pulse start before layer_done -> no accepts, no pixel_valid; after layer_done then start, second frame counts from 0 again.
- abort asserted at counter 400, same cycle as an accept -> no pixel_valid for that byte, state IDLE, in_ready 0; next start gives a full 784-pixel frame from index 0.
- Reset pulsed low asynchronously mid-frame (between clock edges) -> all outputs at reset values immediately; no frame_done.
